// File: rtl/top_pkg.sv
// Shared types for the 2-lane RAW datapath.
package top_pkg;

  localparam int RAW_BITS = 12;

  typedef logic [RAW_BITS-1:0]   raw12_t;
  typedef logic [2*RAW_BITS-1:0] lane_raw_data_t;

endpackage

// File: rtl/rgb2raw_12.sv
// Re-mosaics an RGB pixel stream into GBRG Bayer pixel pairs, 12 bits per sample.
module rgb2raw_12
  import top_pkg::*;
#(
  parameter int LINE_LENGTH = 640,
  parameter int RGB_WIDTH   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RGB_WIDTH-1:0] rgb_in,
  input  logic                 rgb_valid,
  input  logic                 rgb_sof,
  output logic                 rgb_ready,
  output lane_raw_data_t       raw_out,
  output logic                 raw_valid,
  input  logic                 raw_ready,
  output logic                 raw_sof,
  output logic                 raw_eol,
  output logic                 sof_err
);

  // Handshake: a transfer happens on a clock edge where valid and ready are
  // both high; valid never waits on ready, and the payload is held until taken.

  localparam int             PAIRS     = LINE_LENGTH / 2;
  localparam int             CW        = $clog2(PAIRS);
  localparam logic [CW-1:0]  LAST_PAIR = CW'(PAIRS - 1);

  if ($bits(lane_raw_data_t) != 24) begin : g_bad_lane
    $error("rgb2raw_12 supports only a 24-bit lane_raw_data_t");
  end
  if ((LINE_LENGTH % 2) != 0 || LINE_LENGTH < 4) begin : g_bad_line
    $error("rgb2raw_12 needs an even LINE_LENGTH of at least 4");
  end
  if (RGB_WIDTH != 24) begin : g_bad_rgb
    $error("rgb2raw_12 expects RGB_WIDTH of 24");
  end

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_EVEN     = 2'd1,
    ST_ODD      = 2'd2
  } state_e;

  function automatic raw12_t expand8(input logic [7:0] c);
    return {c, c[7:4]};
  endfunction

  state_e         state_q, state_d;
  raw12_t         half_q, half_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           par_q, par_d;
  logic           sof_pend_q, sof_pend_d;
  lane_raw_data_t out_q, out_d;
  logic           valid_q, valid_d;
  logic           rsof_q, rsof_d;
  logic           reol_q, reol_d;
  logic           err_q, err_d;

  logic   accept;
  raw12_t ch_r, ch_g, ch_b;

  assign ch_r = expand8(rgb_in[23:16]);
  assign ch_g = expand8(rgb_in[15:8]);
  assign ch_b = expand8(rgb_in[7:0]);

  assign rgb_ready = (state_q == ST_WAIT_SOF) ? 1'b1 : (~valid_q | raw_ready);
  assign accept    = rgb_valid & rgb_ready;

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    sof_pend_d = sof_pend_q;
    out_d      = out_q;
    valid_d    = valid_q & ~raw_ready;
    rsof_d     = rsof_q;
    reol_d     = reol_q;
    err_d      = 1'b0;

    if (accept) begin
      if (rgb_sof) begin
        // A frame start always restarts at line 0; mid-line it also flags the drop.
        err_d      = (state_q == ST_ODD) | ((state_q == ST_EVEN) & (cnt_q != '0));
        state_d    = ST_ODD;
        cnt_d      = '0;
        par_d      = 1'b0;
        sof_pend_d = 1'b1;
        half_d     = ch_g;
      end else begin
        case (state_q)
          ST_EVEN: begin
            half_d  = par_q ? ch_r : ch_g;
            state_d = ST_ODD;
          end
          ST_ODD: begin
            out_d      = {half_q, (par_q ? ch_g : ch_b)};
            valid_d    = 1'b1;
            rsof_d     = sof_pend_q;
            sof_pend_d = 1'b0;
            reol_d     = (cnt_q == LAST_PAIR);
            if (cnt_q == LAST_PAIR) begin
              cnt_d = '0;
              par_d = ~par_q;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
            state_d = ST_EVEN;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_SOF;
      half_q     <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      sof_pend_q <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      rsof_q     <= 1'b0;
      reol_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      sof_pend_q <= sof_pend_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      rsof_q     <= rsof_d;
      reol_q     <= reol_d;
      err_q      <= err_d;
    end
  end

  assign raw_out   = out_q;
  assign raw_valid = valid_q;
  assign raw_sof   = rsof_q;
  assign raw_eol   = reol_q;
  assign sof_err   = err_q;

endmodule

// File: tb/tb_rgb2raw_12.sv
// Directed bench for rgb2raw_12 with a pixel-position reference model.
module tb_rgb2raw_12;

  localparam int LL = 4;

  logic        clk;
  logic        rst;
  logic [23:0] rgb_in;
  logic        rgb_valid;
  logic        rgb_sof;
  logic        rgb_ready;
  logic [23:0] raw_out;
  logic        raw_valid;
  logic        raw_ready;
  logic        raw_sof;
  logic        raw_eol;
  logic        sof_err;

  rgb2raw_12 #(.LINE_LENGTH(LL), .RGB_WIDTH(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .rgb_in    (rgb_in),
    .rgb_valid (rgb_valid),
    .rgb_sof   (rgb_sof),
    .rgb_ready (rgb_ready),
    .raw_out   (raw_out),
    .raw_valid (raw_valid),
    .raw_ready (raw_ready),
    .raw_sof   (raw_sof),
    .raw_eol   (raw_eol),
    .sof_err   (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] x12(input logic [7:0] c);
    return {c, c[7:4]};
  endfunction

  // Reference model: frame position, expected words {sof,eol,data}
  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];
  bit          m_synced = 0;
  bit          m_first  = 0;
  int          m_idx    = 0;
  int          m_line   = 0;
  logic [23:0] m_even;
  int          exp_err  = 0;
  int          err_seen = 0;
  bit          prev_stall = 0;
  logic [25:0] prev_word;

  always @(negedge clk) begin
    logic [25:0] e;
    logic [23:0] w;
    if (rst) begin
      exp_q.delete();
      m_synced   = 0;
      m_idx      = 0;
      m_line     = 0;
      prev_stall = 0;
    end else begin
      if (!m_synced) begin
        check("wait_ready", {31'd0, rgb_ready}, 32'd1);
        check("wait_valid", {31'd0, raw_valid}, 32'd0);
      end
      if (prev_stall)
        check("stall_hold", {6'd0, raw_sof, raw_eol, raw_out}, {6'd0, prev_word});
      if (raw_valid && raw_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none", {raw_sof, raw_eol, raw_out});
        end else begin
          e = exp_q.pop_front();
          check("word", {6'd0, raw_sof, raw_eol, raw_out}, {6'd0, e});
        end
        got_q.push_back({raw_sof, raw_eol, raw_out});
      end
      prev_stall = raw_valid && !raw_ready;
      prev_word  = {raw_sof, raw_eol, raw_out};
      if (sof_err) err_seen++;

      if (rgb_valid && rgb_ready) begin
        if (rgb_sof) begin
          if (m_synced && m_idx != 0) exp_err++;
          m_synced = 1;
          m_idx    = 0;
          m_line   = 0;
          m_first  = 1;
        end
        if (m_synced) begin
          if (m_idx % 2 == 0) begin
            m_even = rgb_in;
          end else begin
            if (m_line % 2 == 0) w = {x12(m_even[15:8]), x12(rgb_in[7:0])};
            else                 w = {x12(m_even[23:16]), x12(rgb_in[15:8])};
            exp_q.push_back({m_first, (m_idx == LL - 1), w});
            m_first = 0;
          end
          m_idx++;
          if (m_idx == LL) begin
            m_idx = 0;
            m_line++;
          end
        end
      end
    end
  end

  task automatic send_px(input logic [23:0] px, input logic sof);
    bit ok;
    rgb_in    = px;
    rgb_sof   = sof;
    rgb_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = rgb_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: pixel 0x%0h not accepted, expected acceptance", px);
    end
    rgb_valid = 1'b0;
    rgb_sof   = 1'b0;
  endtask

  function automatic logic [23:0] pix(input int k);
    return {8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string name, input int base, input int idx, input logic [25:0] exp);
    if (got_q.size() <= base + idx) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no word expected 0x%0h", name, exp);
    end else begin
      check(name, {6'd0, got_q[base + idx]}, {6'd0, exp});
    end
  endtask

  logic [25:0] lit[6];
  int base;
  int err0;

  initial begin
    lit[0] = {1'b1, 1'b0, 24'h202313};
    lit[1] = {1'b0, 1'b1, 24'h222333};
    lit[2] = {1'b0, 1'b0, 24'h101212};
    lit[3] = {1'b0, 1'b1, 24'h121232};
    lit[4] = {1'b0, 1'b0, 24'h202313};
    lit[5] = {1'b0, 1'b1, 24'h222333};

    rst = 1'b1; rgb_in = '0; rgb_valid = 1'b0; rgb_sof = 1'b0; raw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_raw_valid", {31'd0, raw_valid}, 32'd0);
    check("rst_rgb_ready", {31'd0, rgb_ready}, 32'd1);
    check("rst_raw_out",   {8'd0, raw_out},    32'd0);
    check("rst_raw_sof",   {31'd0, raw_sof},   32'd0);
    check("rst_raw_eol",   {31'd0, raw_eol},   32'd0);
    check("rst_sof_err",   {31'd0, sof_err},   32'd0);
    @(posedge clk); #1;

    // Pixels before any frame start are discarded
    for (int k = 0; k < 3; k++) send_px(pix(k), 1'b0);
    idle(3);

    // Three lines at full rate
    base = got_q.size();
    for (int ln = 0; ln < 3; ln++)
      for (int p = 0; p < LL; p++) send_px(pix(p), (ln == 0 && p == 0));
    idle(3);
    check("frame_words", got_q.size() - base, 6);
    for (int i = 0; i < 6; i++) check_got("frame_lit", base, i, lit[i]);

    // Output stall of 5 cycles mid-line
    base = got_q.size();
    fork
      begin
        for (int ln = 0; ln < 2; ln++)
          for (int p = 0; p < LL; p++) send_px(pix(p), (ln == 0 && p == 0));
      end
      begin
        idle(3);
        raw_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_rgb_ready", {31'd0, rgb_ready}, 32'd0);
        check("stall_raw_valid", {31'd0, raw_valid}, 32'd1);
        @(posedge clk); #1;
        raw_ready = 1'b1;
      end
    join
    idle(3);
    check("stall_words", got_q.size() - base, 4);
    for (int i = 0; i < 4; i++) check_got("stall_lit", base, i, lit[i]);

    // Frame start injected on pixel 3 of line 0
    base = got_q.size();
    err0 = err_seen;
    for (int k = 0; k < 7; k++) send_px(pix(k), (k == 0 || k == 3));
    idle(3);
    check("sof_err_pulses", err_seen - err0, 1);
    check("sof_err_model", err_seen, exp_err);
    check("sof_err_words", got_q.size() - base, 3);
    check_got("sof_err_w0", base, 0, {1'b1, 1'b0, 24'h202313});
    check_got("sof_err_w1", base, 1, {1'b1, 1'b0, 24'h232343});
    check_got("sof_err_w2", base, 2, {1'b0, 1'b1, 24'h252363});

    // Reset during a stall with a word pending
    raw_ready = 1'b0;
    send_px(pix(0), 1'b1);
    send_px(pix(1), 1'b0);
    @(negedge clk);
    check("pre_rst_valid", {31'd0, raw_valid}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'd0, raw_valid}, 32'd0);
    check("post_rst_ready", {31'd0, rgb_ready}, 32'd1);
    @(posedge clk); #1;
    raw_ready = 1'b1;
    base = got_q.size();
    send_px(pix(0), 1'b0);
    send_px(pix(1), 1'b0);
    idle(3);
    check("post_rst_no_word", got_q.size() - base, 0);
    for (int p = 0; p < LL; p++) send_px(pix(p), (p == 0));
    idle(3);
    check("post_rst_words", got_q.size() - base, 2);
    check_got("post_rst_w0", base, 0, lit[0]);
    check_got("post_rst_w1", base, 1, lit[1]);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb2raw_12.md
RGB2RAW_12 -- requirements
Module: rgb2raw_12

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 640, meaning pixels per line; it must be even and at least 4.
REQ-002 SHALL have parameter RGB_WIDTH, default 24, meaning input pixel width; R is [23:16], G is [15:8], B is [7:0].
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rgb_in, input, RGB_WIDTH bits: the RGB pixel.
REQ-006 SHALL have port rgb_valid, input, 1 bit: rgb_in holds a pixel.
REQ-007 SHALL have port rgb_sof, input, 1 bit: the current pixel is pixel 0 of line 0 of a frame; it is qualified by rgb_valid.
REQ-008 SHALL have port rgb_ready, output, 1 bit: the block accepts the pixel this cycle.
REQ-009 SHALL have port raw_out, output, lane_raw_data_t (24 bits): one Bayer pixel pair; [23:12] is the even pixel and [11:0] is the odd pixel.
REQ-010 SHALL have port raw_valid, output, 1 bit: raw_out, raw_sof and raw_eol are valid.
REQ-011 SHALL have port raw_ready, input, 1 bit: the downstream consumer takes the word.
REQ-012 SHALL have port raw_sof, output, 1 bit: marks the first word of a frame.
REQ-013 SHALL have port raw_eol, output, 1 bit: marks the last word of a line.
REQ-014 SHALL have port sof_err, output, 1 bit: one-cycle pulse when rgb_sof arrives in the middle of a line.

Function
REQ-015 SHALL implement the re-mosaic, which is the inverse of the de-Bayer, using GBRG order: even lines output G then B; odd lines output R then G.
REQ-016 SHALL expand each 8-bit channel c to 12 bits as {c[7:0], c[7:4]}, so 0xFF becomes 0xFFF and 0x00 becomes 0x000.
REQ-017 SHALL use an FSM with three states: WAIT_SOF, EVEN and ODD.
REQ-018 In WAIT_SOF the block SHALL hold rgb_ready=1 and discard pixels; a pixel with rgb_valid & rgb_sof is taken as the even pixel and the FSM moves to ODD.
REQ-019 In EVEN, an accepted pixel SHALL be stored in the half register, and the FSM moves to ODD.
REQ-020 In ODD, an accepted pixel SHALL combine with the half register into the output register, and the FSM moves to EVEN.
REQ-021 rgb_ready SHALL equal (~raw_valid | raw_ready) in the EVEN and ODD states.
REQ-022 raw_valid SHALL assert the cycle after the odd pixel is accepted, giving a latency of 1 cycle from the odd pixel to the word.
REQ-023 raw_out, raw_sof and raw_eol SHALL stay stable while raw_valid & ~raw_ready.
REQ-024 The output register SHALL clear raw_valid on raw_ready unless a new word is loaded in the same cycle; the block therefore sustains 1 pixel per clock at full throughput.
REQ-025 The pair counter SHALL count 0..LINE_LENGTH/2-1, incrementing on each word formed.
REQ-026 On the last pair the block SHALL set raw_eol, wrap the counter to 0, and toggle line parity.
REQ-027 Line parity SHALL wrap freely; there is no line-count limit.
REQ-028 raw_sof SHALL be set on the first word formed after a pixel with rgb_sof was accepted.
REQ-029 If rgb_sof is accepted while the FSM is in ODD, or while the pair counter is nonzero, the block SHALL pulse sof_err, drop the partial pair, and restart with parity 0, counter 0, and this pixel as the even pixel.
REQ-030 If the output is stalled, rgb_ready=0 and the input pixel SHALL not be consumed; no data is lost or duplicated.

Reset
REQ-031 On rst the block SHALL set FSM=WAIT_SOF, pair counter=0, parity=0, raw_valid=0, raw_sof=0, raw_eol=0, sof_err=0 and raw_out=0; rgb_ready is then 1.
REQ-032 A reset asserted mid-line or mid-stall SHALL discard all held data; the first word after reset requires a new rgb_sof.

Structure
REQ-033 lane_raw_data_t SHALL be taken from top_pkg, and elaboration SHALL fail if $bits(lane_raw_data_t) != 24; this block is for the 2-lane build only.
REQ-034 top_pkg SHALL gain RAW_BITS=12 and the typedef raw12_t (12 bits); the FSM state enum stays local to the module.
REQ-035 The block SHALL be a single module with no sub-module; the counter width is $clog2(LINE_LENGTH/2).

Verification
REQ-036 LINE_LENGTH=4, SOF, then pixels R,G,B = 0x10,0x20,0x30 / 0x11,0x21,0x31 / 0x12,0x22,0x32 / 0x13,0x23,0x33 -> words {0x202,0x313} with raw_sof=1, then {0x222,0x333} with raw_eol=1.
REQ-037 Continue with line 1 using the same pixels -> words {0x101,0x212}, then {0x121,0x232} with raw_eol=1, and line 2 returns to G/B.
REQ-038 Pixels before the first SOF -> no raw_valid, rgb_ready=1 throughout.
REQ-039 raw_ready held 0 for 5 cycles mid-line -> rgb_ready=0 after one pending word, and the word sequence matches the unstalled run exactly.
REQ-040 SOF injected on pixel 3 of line 0 -> sof_err pulses once, the partial pair is dropped, and the next word has raw_sof=1 with G/B order.
REQ-041 rst asserted for 1 cycle during a stall with raw_valid=1 -> next cycle raw_valid=0, rgb_ready=1, and the block waits for SOF.
